vga_timing_gen: RTL and testbench

Raster timing generator for the VGA path. It produces the pixel coordinates and active-video flag that the pattern/display stage consumes. It also produces the HS/VS/DE outputs sent to the DAC/HDMI encoder, delayed to line up with the display stage's registered RGB. The default timing is 1024x768 at 60 Hz from a 65 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_sync_delay.sv | 42 ++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (1024x768 @ 60 Hz, 65 MHz pixel clock)
// and the 8-colour RGB palette used by the display and timing blocks.
package vga_timing_pkg;

    // Counter width and the largest total either counter can cover
    localparam int CNT_W   = 12;
    localparam int CNT_MAX = 4096;

    // 1024x768 @ 60 Hz horizontal timing (pixels)
    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;

    // 1024x768 @ 60 Hz vertical timing (lines)
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    // 3-bit RGB palette
    typedef logic [2:0] rgb_t;
    localparam rgb_t RGB_BLACK   = 3'b000;
    localparam rgb_t RGB_BLUE    = 3'b001;
    localparam rgb_t RGB_GREEN   = 3'b010;
    localparam rgb_t RGB_CYAN    = 3'b011;
    localparam rgb_t RGB_RED     = 3'b100;
    localparam rgb_t RGB_MAGENTA = 3'b101;
    localparam rgb_t RGB_YELLOW  = 3'b110;
    localparam rgb_t RGB_WHITE   = 3'b111;

    // Period of one axis: active + front porch + sync + back porch
    function automatic int axis_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the display stage.
// master drives coordinates/strobes/syncs, slave consumes them.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] x_pos;
    logic [CNT_W-1:0] y_pos;
    logic             video_active;
    logic             frame_start;
    logic             line_start;
    logic             hs;
    logic             vs;
    logic             de;

    modport master (
        output x_pos, y_pos, video_active,
        output frame_start, line_start,
        output hs, vs, de
    );

    modport slave (
        input x_pos, y_pos, video_active,
        input frame_start, line_start,
        input hs, vs, de
    );

endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH shift register with an async reset value.
// Ports: clk, rst (async, active-high), rst_val, d in; q out (q = d when DEPTH=0).
module vga_sync_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] sr_q [DEPTH];
            logic [WIDTH-1:0] sr_d [DEPTH];

            always_comb begin
                sr_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr_q[i] <= rst_val;
                    end
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters decoded into registered pixel
// coordinates, active flag and start strobes, plus hs/vs/de delayed by
// PIPE_DLY to line up with the display stage's registered RGB.
// Ports: clk, rst (async, active-high); vid (master) carries x_pos, y_pos,
// video_active, frame_start, line_start, hs, vs, de.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   HORI_ACTIVE = H_ACTIVE,
    parameter int   HORI_FP     = H_FP,
    parameter int   HORI_SYNCP  = H_SYNC,
    parameter int   HORI_BP     = H_BP,
    parameter int   VERT_ACTIVE = V_ACTIVE,
    parameter int   VERT_FP     = V_FP,
    parameter int   VERT_SYNCP  = V_SYNC,
    parameter int   VERT_BP     = V_BP,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIPE_DLY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vid
);

    localparam int H_TOTAL =
        axis_total(HORI_ACTIVE, HORI_FP, HORI_SYNCP, HORI_BP);
    localparam int V_TOTAL =
        axis_total(VERT_ACTIVE, VERT_FP, VERT_SYNCP, VERT_BP);

    generate
        if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be 0..4");
        end
    endgenerate

    // Region bounds are one bit wider so an end of 4096 does not wrap
    localparam logic [CNT_W:0] H_ACT_E  = (CNT_W+1)'(HORI_ACTIVE);
    localparam logic [CNT_W:0] H_SYNC_S = (CNT_W+1)'(HORI_ACTIVE + HORI_FP);
    localparam logic [CNT_W:0] H_SYNC_E =
        (CNT_W+1)'(HORI_ACTIVE + HORI_FP + HORI_SYNCP);
    localparam logic [CNT_W:0] V_ACT_E  = (CNT_W+1)'(VERT_ACTIVE);
    localparam logic [CNT_W:0] V_SYNC_S = (CNT_W+1)'(VERT_ACTIVE + VERT_FP);
    localparam logic [CNT_W:0] V_SYNC_E =
        (CNT_W+1)'(VERT_ACTIVE + VERT_FP + VERT_SYNCP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] x_pos_q, x_pos_d;
    logic [CNT_W-1:0] y_pos_q, y_pos_d;
    logic             active_q, active_d;
    logic             frame_start_q, frame_start_d;
    logic             line_start_q, line_start_d;
    logic             hs_int_q, hs_int_d;
    logic             vs_int_q, vs_int_d;
    logic             h_act, v_act, h_sync, v_sync;
    logic [2:0]       dly_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Decode the current count; the result lands in the output flops
    always_comb begin
        h_act  = {1'b0, h_cnt_q} < H_ACT_E;
        v_act  = {1'b0, v_cnt_q} < V_ACT_E;
        h_sync = {1'b0, h_cnt_q} >= H_SYNC_S &&
                 {1'b0, h_cnt_q} <  H_SYNC_E;
        v_sync = {1'b0, v_cnt_q} >= V_SYNC_S &&
                 {1'b0, v_cnt_q} <  V_SYNC_E;

        x_pos_d       = h_act ? h_cnt_q : '0;
        y_pos_d       = v_act ? v_cnt_q : '0;
        active_d      = h_act && v_act;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        line_start_d  = (h_cnt_q == '0) && v_act;
        hs_int_d      = h_sync ? HS_POL : ~HS_POL;
        vs_int_d      = v_sync ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            hs_int_q      <= ~HS_POL;
            vs_int_q      <= ~VS_POL;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            hs_int_q      <= hs_int_d;
            vs_int_q      <= vs_int_d;
        end
    end

    vga_sync_delay #(
        .DEPTH (PIPE_DLY),
        .WIDTH (3)
    ) u_sync_dly (
        .clk     (clk),
        .rst     (rst),
        .rst_val ({~HS_POL, ~VS_POL, 1'b0}),
        .d       ({hs_int_q, vs_int_q, active_q}),
        .q       (dly_q)
    );

    assign vid.x_pos        = x_pos_q;
    assign vid.y_pos        = y_pos_q;
    assign vid.video_active = active_q;
    assign vid.frame_start  = frame_start_q;
    assign vid.line_start   = line_start_q;
    assign vid.hs           = dly_q[2];
    assign vid.vs           = dly_q[1];
    assign vid.de           = dly_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four timing configurations share
// one clock and a randomly pulsed async reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        act;
        logic        fs;
        logic        ls;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        int dly;
        bit hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if2 ();
    vga_timing_gen_if if3 ();

    // Default 1024x768 timing, PIPE_DLY=1
    vga_timing_gen u_def (
        .clk (clk),
        .rst (rst),
        .vid (if0)
    );

    // Default timing, PIPE_DLY=3
    vga_timing_gen #(.PIPE_DLY(3)) u_d3 (
        .clk (clk),
        .rst (rst),
        .vid (if1)
    );

    // Reduced 8x4 raster, PIPE_DLY=0
    vga_timing_gen #(
        .HORI_ACTIVE(8), .HORI_FP(1), .HORI_SYNCP(1), .HORI_BP(1),
        .VERT_ACTIVE(4), .VERT_FP(1), .VERT_SYNCP(1), .VERT_BP(1),
        .PIPE_DLY(0)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vid (if2)
    );

    // Reduced raster, positive syncs, PIPE_DLY=3
    vga_timing_gen #(
        .HORI_ACTIVE(8), .HORI_FP(1), .HORI_SYNCP(1), .HORI_BP(1),
        .VERT_ACTIVE(4), .VERT_FP(1), .VERT_SYNCP(1), .VERT_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3)
    ) u_small3 (
        .clk (clk),
        .rst (rst),
        .vid (if3)
    );

    exp_t obs [4];
    assign obs[0] = {if0.x_pos, if0.y_pos, if0.video_active, if0.frame_start,
                     if0.line_start, if0.hs, if0.vs, if0.de};
    assign obs[1] = {if1.x_pos, if1.y_pos, if1.video_active, if1.frame_start,
                     if1.line_start, if1.hs, if1.vs, if1.de};
    assign obs[2] = {if2.x_pos, if2.y_pos, if2.video_active, if2.frame_start,
                     if2.line_start, if2.hs, if2.vs, if2.de};
    assign obs[3] = {if3.x_pos, if3.y_pos, if3.video_active, if3.frame_start,
                     if3.line_start, if3.hs, if3.vs, if3.de};

    cfg_t cfg [4];
    exp_t exp_q [4][$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   k      = 0;

    // Outputs produced from raster position n (n<0: still in reset)
    function automatic exp_t decode(int n, cfg_t c);
        exp_t e;
        int ht, vt, h, v;
        e.x = '0; e.y = '0;
        e.act = 1'b0; e.fs = 1'b0; e.ls = 1'b0; e.de = 1'b0;
        e.hs = ~c.hp; e.vs = ~c.vp;
        if (n < 0) return e;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        h = n % ht;
        v = (n / ht) % vt;
        if (h < c.ha) e.x = 12'(h);
        if (v < c.va) e.y = 12'(v);
        e.act = (h < c.ha) && (v < c.va);
        e.fs  = (h == 0) && (v == 0);
        e.ls  = (h == 0) && (v < c.va);
        if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) e.hs = c.hp;
        if (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) e.vs = c.vp;
        e.de = e.act;
        return e;
    endfunction

    // k = clock edges since reset release (0 = in reset)
    function automatic exp_t model(int kk, cfg_t c);
        exp_t u, d;
        u = decode(kk - 1, c);
        d = decode(kk - 1 - c.dly, c);
        u.hs = d.hs;
        u.vs = d.vs;
        u.de = d.de;
        return u;
    endfunction

    task automatic cmp(string nm, int i, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t k=%0d got=%0h exp=%0h",
                     nm, i, $time, k, a, e);
        end
    endtask

    // One clock: account for the edge, then set rst and queue expectations
    task automatic cycle(bit rst_next);
        @(posedge clk);
        #1;
        if (!rst) k = k + 1;
        #1;
        rst = rst_next;
        if (rst) k = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q[i].push_back(model(k, cfg[i]));
        end
    endtask

    // Monitor: compare every presented output against the queue head
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (exp_q[i].size() > 0) begin
                    exp_t e;
                    exp_t o;
                    e = exp_q[i].pop_front();
                    o = obs[i];
                    cmp("x_pos", i, 32'(o.x), 32'(e.x));
                    cmp("y_pos", i, 32'(o.y), 32'(e.y));
                    cmp("video_active", i, 32'(o.act), 32'(e.act));
                    cmp("frame_start", i, 32'(o.fs), 32'(e.fs));
                    cmp("line_start", i, 32'(o.ls), 32'(e.ls));
                    cmp("hs", i, 32'(o.hs), 32'(e.hs));
                    cmp("vs", i, 32'(o.vs), 32'(e.vs));
                    cmp("de", i, 32'(o.de), 32'(e.de));
                end
            end
        end
    end

    initial begin
        cfg[0] = '{1024, 24, 136, 160, 768, 3, 6, 29, 1, 1'b0, 1'b0};
        cfg[1] = '{1024, 24, 136, 160, 768, 3, 6, 29, 3, 1'b0, 1'b0};
        cfg[2] = '{8, 1, 1, 1, 4, 1, 1, 1, 0, 1'b0, 1'b0};
        cfg[3] = '{8, 1, 1, 1, 4, 1, 1, 1, 3, 1'b1, 1'b1};

        // Held in reset, then three full lines of the default raster
        repeat (4) cycle(1'b1);
        repeat (3 * 1344 + 60) cycle(1'b0);

        // Random mid-raster async resets of random length
        for (int s = 0; s < 8; s++) begin
            repeat ($urandom_range(1, 3)) cycle(1'b1);
            repeat ($urandom_range(20, 500)) cycle(1'b0);
        end

        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            cmp("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
